wishbone_arbiter: RTL and testbench
===================================

Name: wishbone_arbiter

Overview:
- Four-port round-robin arbiter. It shares one Wishbone master bus (adr/dat/we/sel/stb/cyc out, dat/ack in) among four requesters, for example the CPU, DMA, debug and video fetch.
- It sits between the requesters and the single wishbone_master-facing interconnect port.
- It grants whole cycles: the owner holds the bus while its cyc is high.
- A watchdog aborts the owner's cycle when the slave never acks.

Parameters:
- TIMEOUT, 16: max consecutive unacked strobe cycles before abort; legal range 2..255.
- SEL_W, 4: byte-select width per master.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- m_cyc_i  in  4  per-master cycle request, bit k = master k.
- m_stb_i  in  4  per-master strobe.
- m_we_i  in  4  per-master write enable.
- m_sel_i  in  4*SEL_W  per-master byte selects; master k at [k*SEL_W +: SEL_W].
- m_adr_i  in  128  per-master address; master k at [k*32 +: 32].
- m_dat_i  in  128  per-master write data; same packing as m_adr_i.
- m_dat_o  out  32  read data, broadcast copy of s_dat_i.
- m_ack_o  out  4  ack routed to the owner only.
- m_err_o  out  4  one-cycle timeout abort pulse to the offending owner.
- gnt_o  out  4  registered one-hot grant; all-zero when the bus is free.
- s_adr_o  out  32  shared-bus address.
- s_dat_o  out  32  shared-bus write data.
- s_we_o  out  1  shared-bus write enable.
- s_sel_o  out  SEL_W  shared-bus byte selects.
- s_stb_o  out  1  shared-bus strobe.
- s_cyc_o  out  1  shared-bus cycle.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE, gnt_o=0, m_err_o=0, watchdog counter=0.
  - Priority pointer last=3, so master 0 wins first.
  - All s_* outputs 0, m_ack_o=0.
- State machine (IDLE, BUSY, ABORT):
  - IDLE: if any m_cyc_i bit is set, pick the first set bit searching last+1, last+2, ... (mod 4). Register gnt_o=onehot(winner), winner=idx, go to BUSY. Otherwise stay in IDLE.
  - BUSY, owner's m_cyc_i=0: gnt_o<=0, last<=winner, go to IDLE.
  - BUSY, watchdog expires: gnt_o<=0, m_err_o[winner]<=1, last<=winner, go to ABORT.
  - ABORT: lasts one cycle; m_err_o<=0, go to IDLE.
- Latency:
  - Request at edge N (bus free) gives gnt_o and s_cyc_o at N+1.
  - Owner drops cyc at edge N: IDLE at N+1, next grant at N+2. There is always one idle turnaround cycle between owners.
- Datapath:
  - When in BUSY: s_cyc_o = m_cyc_i[winner], s_stb_o = m_stb_i[winner]; s_adr_o, s_dat_o, s_we_o and s_sel_o are muxed combinationally from winner.
  - When not in BUSY: all s_* outputs are 0.
  - m_ack_o[winner] = s_ack_i & (state==BUSY); all other bits are 0.
  - m_dat_o = s_dat_i always; masters qualify it with their own ack.
- Watchdog:
  - The 8-bit counter clears on s_ack_i, when s_stb_o=0, or outside BUSY.
  - It increments each BUSY cycle with s_stb_o=1 and s_ack_i=0.
  - Expiry: the counter equals TIMEOUT-1 and the current cycle is still strobed and unacked. The abort takes effect at the next edge.
  - An ack arriving in the expiry cycle wins: it is passed through and the counter clears. ack has priority over timeout.
- Edge cases:
  - Owner drops cyc in the same cycle as s_ack_i: the ack is routed, then release proceeds.
  - A late s_ack_i arriving in ABORT or IDLE is dropped; no m_ack_o bit asserts.
  - Non-owner requests are ignored during BUSY and ABORT. Requesters wait with cyc held high.
  - An aborted master that keeps cyc high competes again from IDLE, at lowest priority.
  - Reset mid-cycle: all outputs go to their reset values immediately. The in-flight transfer is lost and no ack or err is produced.
- gnt_o is always one-hot or zero.

Test Plan:
- Single master: m_cyc_i=0001 with stb, adr=0x1000_0000, we=1, dat=0xDEADBEEF; slave acks after 2 cycles. Required: gnt_o=0001 one cycle after request, s_adr_o/s_dat_o match, m_ack_o=0001 for exactly one cycle, gnt_o=0 the cycle after cyc drops.
- Round robin: all four masters request continuously, each doing one single-beat transfer then dropping cyc for one cycle. Required: grant order 0,1,2,3,0; exactly one idle cycle between grants; no m_ack_o bit outside its owner.
- Burst hold: master 2 keeps cyc high for 5 acked strobes while master 0 requests. Required: gnt_o stays 0100 for all 5 acks; master 0 is granted 2 cycles after master 2 drops cyc.
- Timeout: TIMEOUT=16; master 1 strobes and the slave never acks. Required: after 16 strobed cycles, m_err_o=0010 for exactly one cycle, s_cyc_o=0, and a pending master 3 is granted next.
- Ack at limit: slave acks on the 16th strobed cycle. Required: m_ack_o=0010 and no m_err_o.
- Async reset: rst_i low mid-burst while gnt_o=1000. Required: gnt_o=0 and s_cyc_o=0 immediately without a clock edge. After release with all four requesting, master 0 is granted first.

Source files
------------

// File: rtl/wishbone_arbiter.sv
// -----------------------------------------------------------------------------
// wishbone_arbiter
//   Four-port round-robin arbiter that shares one Wishbone master bus among
//   four requesters. A grant covers a whole cycle: the owner keeps the bus
//   for as long as it holds its cyc high. A watchdog aborts the owner's
//   cycle when the slave leaves a strobe unacknowledged for TIMEOUT
//   consecutive cycles. There is always one idle cycle between two owners.
//
// Parameters
//   TIMEOUT  max consecutive unacked strobe cycles before abort (2..255)
//   SEL_W    byte-select width per master
//
// Ports
//   clk_i    system clock, rising edge
//   rst_i    asynchronous reset, active-low
//   m_cyc_i  per-master cycle request, bit k = master k
//   m_stb_i  per-master strobe
//   m_we_i   per-master write enable
//   m_sel_i  per-master byte selects, master k at [k*SEL_W +: SEL_W]
//   m_adr_i  per-master address, master k at [k*32 +: 32]
//   m_dat_i  per-master write data, same packing as m_adr_i
//   m_dat_o  read data, broadcast copy of s_dat_i
//   m_ack_o  ack routed to the current owner only
//   m_err_o  one-cycle timeout abort pulse to the offending owner
//   gnt_o    registered one-hot grant, zero while the bus is free
//   s_*_o    shared-bus address/data/we/sel/stb/cyc towards the slave
//   s_dat_i  slave read data
//   s_ack_i  slave ack
// -----------------------------------------------------------------------------
module wishbone_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int SEL_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [3:0]         m_cyc_i,
  input  logic [3:0]         m_stb_i,
  input  logic [3:0]         m_we_i,
  input  logic [4*SEL_W-1:0] m_sel_i,
  input  logic [127:0]       m_adr_i,
  input  logic [127:0]       m_dat_i,
  output logic [31:0]        m_dat_o,
  output logic [3:0]         m_ack_o,
  output logic [3:0]         m_err_o,
  output logic [3:0]         gnt_o,
  output logic [31:0]        s_adr_o,
  output logic [31:0]        s_dat_o,
  output logic               s_we_o,
  output logic [SEL_W-1:0]   s_sel_o,
  output logic               s_stb_o,
  output logic               s_cyc_o,
  input  logic [31:0]        s_dat_i,
  input  logic               s_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  // Counter value on the last strobed cycle allowed to go unacked.
  localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT - 1);

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  state_t     state_r, state_n_s;
  logic [3:0] gnt_r, gnt_n_s;
  logic [3:0] err_r, err_n_s;
  logic [1:0] winner_r, winner_n_s;
  logic [1:0] last_r, last_n_s;
  logic [7:0] wdog_r, wdog_n_s;
  logic [1:0] pick_idx_s;
  logic       pick_vld_s;
  logic       busy_s;
  logic       expire_s;

  assign busy_s  = (state_r == ST_BUSY);
  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_r;
  assign m_err_o = err_r;

  // Round-robin search: first requester after the previous owner, wrapping.
  always_comb begin
    logic [1:0] cand;
    cand       = 2'd0;
    pick_vld_s = 1'b0;
    pick_idx_s = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = last_r + 2'd1 + 2'(i);
      if (!pick_vld_s && m_cyc_i[cand]) begin
        pick_vld_s = 1'b1;
        pick_idx_s = cand;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Shared-bus mux and ack routing; everything is quiet outside BUSY.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_sel_o = '0;
    m_ack_o = 4'b0000;
    if (busy_s) begin
      s_cyc_o = m_cyc_i[winner_r];
      s_stb_o = m_stb_i[winner_r];
      s_we_o  = m_we_i[winner_r];
      s_adr_o = m_adr_i[{winner_r, 5'd0} +: 32];
      s_dat_o = m_dat_i[{winner_r, 5'd0} +: 32];
      s_sel_o = m_sel_i[int'(winner_r) * SEL_W +: SEL_W];
      m_ack_o = s_ack_i ? onehot(winner_r) : 4'b0000;
    end else begin
      m_ack_o = 4'b0000;
    end
  end

  // An ack in the limit cycle suppresses expiry, so ack beats timeout.
  assign expire_s = busy_s && s_stb_o && !s_ack_i && (wdog_r == WDOG_LIMIT);

  // Next-state, grant, priority pointer and watchdog update.
  always_comb begin
    state_n_s  = state_r;
    gnt_n_s    = gnt_r;
    winner_n_s = winner_r;
    last_n_s   = last_r;
    err_n_s    = 4'b0000;
    wdog_n_s   = 8'd0;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          gnt_n_s    = onehot(pick_idx_s);
          winner_n_s = pick_idx_s;
          state_n_s  = ST_BUSY;
        end else begin
          gnt_n_s = 4'b0000;
        end
      end
      ST_BUSY: begin
        if (!m_cyc_i[winner_r]) begin
          gnt_n_s   = 4'b0000;
          last_n_s  = winner_r;
          state_n_s = ST_IDLE;
        end else if (expire_s) begin
          gnt_n_s   = 4'b0000;
          err_n_s   = onehot(winner_r);
          last_n_s  = winner_r;
          state_n_s = ST_ABORT;
        end else if (s_stb_o && !s_ack_i) begin
          wdog_n_s = wdog_r + 8'd1;
        end else begin
          wdog_n_s = 8'd0;
        end
      end
      ST_ABORT: begin
        gnt_n_s   = 4'b0000;
        state_n_s = ST_IDLE;
      end
      default: begin
        gnt_n_s   = 4'b0000;
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; last resets to 3 so master 0 wins first.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= ST_IDLE;
      gnt_r    <= 4'b0000;
      err_r    <= 4'b0000;
      winner_r <= 2'd0;
      last_r   <= 2'd3;
      wdog_r   <= 8'd0;
    end else begin
      state_r  <= state_n_s;
      gnt_r    <= gnt_n_s;
      err_r    <= err_n_s;
      winner_r <= winner_n_s;
      last_r   <= last_n_s;
      wdog_r   <= wdog_n_s;
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wishbone_arbiter
//   Self-checking bench for wishbone_arbiter. Expected grants (one-hot and
//   the address seen on the shared bus) are queued when requests are driven
//   and compared by a monitor whenever gnt_o rises from zero. Directed
//   per-cycle checks cover acks, idle turnaround, timeout and reset.
// -----------------------------------------------------------------------------
module tb_wishbone_arbiter;

  localparam int TIMEOUT = 16;
  localparam int SEL_W   = 4;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [3:0]         m_cyc_i;
  logic [3:0]         m_stb_i;
  logic [3:0]         m_we_i;
  logic [4*SEL_W-1:0] m_sel_i;
  logic [127:0]       m_adr_i;
  logic [127:0]       m_dat_i;
  logic [31:0]        m_dat_o;
  logic [3:0]         m_ack_o;
  logic [3:0]         m_err_o;
  logic [3:0]         gnt_o;
  logic [31:0]        s_adr_o;
  logic [31:0]        s_dat_o;
  logic               s_we_o;
  logic [SEL_W-1:0]   s_sel_o;
  logic               s_stb_o;
  logic               s_cyc_o;
  logic [31:0]        s_dat_i;
  logic               s_ack_i;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  logic [3:0]  exp_gnt_q[$];
  logic [31:0] exp_adr_q[$];
  logic [3:0]  prev_gnt = 4'b0000;
  logic [3:0]  mon_gnt;
  logic [31:0] mon_adr;

  wishbone_arbiter #(.TIMEOUT(TIMEOUT), .SEL_W(SEL_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .gnt_o(gnt_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] oh(input int k);
    logic [3:0] r;
    r = 4'b0001 << k;
    return r;
  endfunction

  function automatic logic [31:0] adr_of(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h0000_0100;
  endfunction

  function automatic logic [31:0] dat_of(input int k);
    return 32'hDEAD_BEEF ^ (32'(k) * 32'h0101_0101);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int k);
    exp_gnt_q.push_back(oh(k));
    exp_adr_q.push_back(adr_of(k));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Scoreboard monitor: every new grant must match the next queued entry.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      prev_gnt = 4'b0000;
    end else begin
      if (gnt_o != 4'b0000 && prev_gnt == 4'b0000) begin
        if (exp_gnt_q.size() == 0) begin
          check_eq("sb_unexpected_gnt", 32'(gnt_o), 32'd0);
        end else begin
          mon_gnt = exp_gnt_q.pop_front();
          mon_adr = exp_adr_q.pop_front();
          check_eq("sb_gnt", 32'(gnt_o), 32'(mon_gnt));
          check_eq("sb_adr", s_adr_o, mon_adr);
        end
      end
      prev_gnt = gnt_o;
    end
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    m_we_i  = 4'b0101;
    s_ack_i = 1'b0;
    s_dat_i = 32'hCAFE_F00D;
    m_sel_i = '0;
    m_adr_i = '0;
    m_dat_i = '0;
    for (int k = 0; k < 4; k++) begin
      m_adr_i[k*32 +: 32]       = adr_of(k);
      m_dat_i[k*32 +: 32]       = dat_of(k);
      m_sel_i[k*SEL_W +: SEL_W] = oh(k);
    end

    // Reset state.
    #1 rst_i = 1'b0;
    #2;
    check_eq("rst_gnt",   32'(gnt_o),   32'd0);
    check_eq("rst_err",   32'(m_err_o), 32'd0);
    check_eq("rst_ack",   32'(m_ack_o), 32'd0);
    check_eq("rst_scyc",  32'(s_cyc_o), 32'd0);
    check_eq("rst_sadr",  s_adr_o,      32'd0);
    check_eq("rst_mdato", m_dat_o,      32'hCAFE_F00D);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    // Round robin: all four request; grants go 0,1,2,3,0 with one idle gap.
    m_cyc_i = 4'b1111;
    m_stb_i = 4'b1111;
    for (int g = 0; g < 5; g++) push_exp(g % 4);
    #1 check_eq("rr_pre_gnt", 32'(gnt_o), 32'd0);
    tick();
    for (int g = 0; g < 5; g++) begin
      s_ack_i = 1'b1;
      m_cyc_i = ~oh(g % 4);
      m_stb_i = ~oh(g % 4);
      #1;
      check_eq("rr_gnt", 32'(gnt_o),   32'(oh(g % 4)));
      check_eq("rr_ack", 32'(m_ack_o), 32'(oh(g % 4)));
      check_eq("rr_adr", s_adr_o,      adr_of(g % 4));
      tick();
      s_ack_i = 1'b0;
      m_cyc_i = (g == 4) ? 4'b0000 : 4'b1111;
      m_stb_i = m_cyc_i;
      #1;
      check_eq("rr_idle_gnt", 32'(gnt_o),   32'd0);
      check_eq("rr_idle_ack", 32'(m_ack_o), 32'd0);
      tick();
    end

    // Single master 0, slave acks on the third granted cycle.
    m_cyc_i = 4'b0001;
    m_stb_i = 4'b0001;
    push_exp(0);
    #1 check_eq("sm_pre_gnt", 32'(gnt_o), 32'd0);
    tick();
    #1;
    check_eq("sm_gnt",  32'(gnt_o),   32'b0001);
    check_eq("sm_scyc", 32'(s_cyc_o), 32'd1);
    check_eq("sm_dat",  s_dat_o,      32'hDEAD_BEEF);
    check_eq("sm_we",   32'(s_we_o),  32'd1);
    check_eq("sm_sel",  32'(s_sel_o), 32'b0001);
    check_eq("sm_ack0", 32'(m_ack_o), 32'd0);
    tick();
    #1 check_eq("sm_ack1", 32'(m_ack_o), 32'd0);
    tick();
    s_ack_i = 1'b1;
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    #1 check_eq("sm_ack", 32'(m_ack_o), 32'b0001);
    tick();
    s_ack_i = 1'b0;
    #1;
    check_eq("sm_rel_gnt", 32'(gnt_o),   32'd0);
    check_eq("sm_rel_ack", 32'(m_ack_o), 32'd0);

    // Burst hold: master 2 keeps the bus for 5 acks while master 0 waits.
    m_cyc_i = 4'b0101;
    m_stb_i = 4'b0101;
    push_exp(2);
    push_exp(0);
    tick();
    for (int b = 0; b < 5; b++) begin
      s_ack_i = 1'b1;
      #1;
      check_eq("bh_gnt", 32'(gnt_o),   32'b0100);
      check_eq("bh_ack", 32'(m_ack_o), 32'b0100);
      tick();
    end
    s_ack_i = 1'b0;
    m_cyc_i = 4'b0001;
    m_stb_i = 4'b0001;
    #1 check_eq("bh_drop_gnt", 32'(gnt_o), 32'b0100);
    tick();
    #1 check_eq("bh_idle_gnt", 32'(gnt_o), 32'd0);
    tick();
    #1 check_eq("bh_m0_gnt", 32'(gnt_o), 32'b0001);
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    tick();

    // Timeout: master 1 never acked, master 3 pending behind it.
    m_cyc_i = 4'b1010;
    m_stb_i = 4'b1010;
    push_exp(1);
    push_exp(3);
    tick();
    for (int c = 1; c <= TIMEOUT; c++) begin
      #1;
      check_eq("to_gnt", 32'(gnt_o),   32'b0010);
      check_eq("to_err", 32'(m_err_o), 32'd0);
      tick();
    end
    s_ack_i = 1'b1;
    #1;
    check_eq("to_abort_err",  32'(m_err_o), 32'b0010);
    check_eq("to_abort_scyc", 32'(s_cyc_o), 32'd0);
    check_eq("to_abort_gnt",  32'(gnt_o),   32'd0);
    check_eq("to_late_ack",   32'(m_ack_o), 32'd0);
    tick();
    s_ack_i = 1'b0;
    #1;
    check_eq("to_err_clr",  32'(m_err_o), 32'd0);
    check_eq("to_idle_gnt", 32'(gnt_o),   32'd0);
    tick();
    #1 check_eq("to_m3_gnt", 32'(gnt_o), 32'b1000);
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    tick();

    // Ack on the limit cycle wins over the watchdog.
    m_cyc_i = 4'b0010;
    m_stb_i = 4'b0010;
    push_exp(1);
    tick();
    for (int c = 1; c < TIMEOUT; c++) begin
      #1 check_eq("al_err", 32'(m_err_o), 32'd0);
      tick();
    end
    s_ack_i = 1'b1;
    #1 check_eq("al_ack", 32'(m_ack_o), 32'b0010);
    tick();
    s_ack_i = 1'b0;
    #1;
    check_eq("al_no_err", 32'(m_err_o), 32'd0);
    check_eq("al_gnt",    32'(gnt_o),   32'b0010);
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    tick();
    #1 check_eq("al_rel_gnt", 32'(gnt_o), 32'd0);

    // Asynchronous reset in the middle of a master 3 burst.
    m_cyc_i = 4'b1000;
    m_stb_i = 4'b1000;
    push_exp(3);
    tick();
    s_ack_i = 1'b1;
    #1;
    check_eq("ar_gnt", 32'(gnt_o),   32'b1000);
    check_eq("ar_ack", 32'(m_ack_o), 32'b1000);
    tick();
    rst_i = 1'b0;
    #1;
    check_eq("ar_rst_gnt",  32'(gnt_o),   32'd0);
    check_eq("ar_rst_scyc", 32'(s_cyc_o), 32'd0);
    check_eq("ar_rst_ack",  32'(m_ack_o), 32'd0);
    check_eq("ar_rst_err",  32'(m_err_o), 32'd0);
    s_ack_i = 1'b0;
    m_cyc_i = 4'b1111;
    m_stb_i = 4'b1111;
    tick();
    #1 check_eq("ar_hold_gnt", 32'(gnt_o), 32'd0);
    rst_i = 1'b1;
    push_exp(0);
    tick();
    #1 check_eq("ar_first_gnt", 32'(gnt_o), 32'b0001);
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    tick();
    tick();

    check_eq("sb_drain", 32'(exp_gnt_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
